// File: rtl/screen_mode_ctrl_pkg.sv
// Shared types and keycode constants for the screen sequencer.
package screen_mode_ctrl_pkg;

    typedef enum logic [1:0] {
        SCR_START = 2'd0,
        SCR_GAME  = 2'd1,
        SCR_WAIT  = 2'd2
    } screen_t;

    typedef enum logic {
        REQ_NEW  = 1'b0,
        REQ_NEXT = 1'b1
    } req_kind_t;

    localparam logic [7:0] KEYCODE_ENTER = 8'h28;
    localparam logic [7:0] KEYCODE_SPACE = 8'h2C;

endpackage

// File: rtl/screen_mode_ctrl_key_edge_detect.sv
// Rising-edge detector for one keycode: a held key yields a single event.
module key_edge_detect #(
    parameter logic [7:0] KEY = 8'h00
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] keycode,
    output logic       key_event
);

    logic [7:0] r_prev;

    always_ff @(posedge clk) begin
        if (!reset_n) r_prev <= 8'h00;
        else          r_prev <= keycode;
    end

    assign key_event = (keycode == KEY) && (r_prev != KEY);

endmodule

// File: rtl/screen_mode_ctrl.sv
// Start/game/wait screen sequencer; switches only on frame_start edges.
// Optional SCREEN_AUTO_ADVANCE_EN: leave WAIT automatically once wait_elapsed is set.
module screen_mode_ctrl
    import screen_mode_ctrl_pkg::*;
#(
    parameter logic [7:0] KEY_START   = KEYCODE_ENTER,
    parameter logic [7:0] KEY_CONT    = KEYCODE_SPACE,
    parameter int         WAIT_FRAMES = 120,
    parameter int         FCNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic [7:0] keycode,
    input  logic       hand_done,
    input  logic       game_over,
    output logic       start_state,
    output logic       game_state,
    output logic       wait_state,
    output logic       new_game,
    output logic       next_hand,
    output logic       wait_elapsed
);

    localparam logic [FCNT_W-1:0] WAIT_MAX = FCNT_W'(WAIT_FRAMES);

    logic        w_ev_start, w_ev_cont, w_cont_req;
    logic        w_ev_vld, w_req_vld, w_apply;
    screen_t     w_ev_scr, w_req_scr, w_nxt_scr;
    req_kind_t   w_ev_kind, w_req_kind;
    logic [FCNT_W-1:0] w_fcnt_nxt;

    screen_t     r_scr, r_pend_scr;
    req_kind_t   r_pend_kind;
    logic        r_pend_vld, r_over;
    logic [FCNT_W-1:0] r_fcnt;
    logic        r_start_state, r_game_state, r_wait_state;
    logic        r_new_game, r_next_hand, r_wait_elapsed;

    key_edge_detect #(.KEY(KEY_START)) u_key_start (
        .clk       (clk),
        .reset_n   (reset_n),
        .keycode   (keycode),
        .key_event (w_ev_start)
    );

    key_edge_detect #(.KEY(KEY_CONT)) u_key_cont (
        .clk       (clk),
        .reset_n   (reset_n),
        .keycode   (keycode),
        .key_event (w_ev_cont)
    );

`ifdef SCREEN_AUTO_ADVANCE_EN
    assign w_cont_req = w_ev_cont | r_wait_elapsed;
`else
    assign w_cont_req = w_ev_cont;
`endif

    // A new event is only considered while nothing is pending.
    always_comb begin
        w_ev_vld  = 1'b0;
        w_ev_scr  = SCR_GAME;
        w_ev_kind = REQ_NEW;
        if (!r_pend_vld) begin
            case (r_scr)
                SCR_START: begin
                    if (w_ev_start) begin
                        w_ev_vld  = 1'b1;
                        w_ev_scr  = SCR_GAME;
                        w_ev_kind = REQ_NEW;
                    end
                end
                SCR_GAME: begin
                    if (hand_done) begin
                        w_ev_vld = 1'b1;
                        w_ev_scr = SCR_WAIT;
                    end
                end
                SCR_WAIT: begin
                    if (r_wait_elapsed && w_cont_req) begin
                        w_ev_vld  = 1'b1;
                        w_ev_scr  = r_over ? SCR_START : SCR_GAME;
                        w_ev_kind = REQ_NEXT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_req_vld  = r_pend_vld | w_ev_vld;
        w_req_scr  = r_pend_vld ? r_pend_scr  : w_ev_scr;
        w_req_kind = r_pend_vld ? r_pend_kind : w_ev_kind;
        w_apply    = frame_start & w_req_vld;
        w_nxt_scr  = w_apply ? w_req_scr : r_scr;

        w_fcnt_nxt = r_fcnt;
        if (w_apply && (w_req_scr == SCR_WAIT))
            w_fcnt_nxt = '0;
        else if ((r_scr == SCR_WAIT) && frame_start && (r_fcnt != WAIT_MAX))
            w_fcnt_nxt = r_fcnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_scr          <= SCR_START;
            r_pend_vld     <= 1'b0;
            r_pend_scr     <= SCR_START;
            r_pend_kind    <= REQ_NEW;
            r_over         <= 1'b0;
            r_fcnt         <= '0;
            r_start_state  <= 1'b1;
            r_game_state   <= 1'b0;
            r_wait_state   <= 1'b0;
            r_new_game     <= 1'b0;
            r_next_hand    <= 1'b0;
            r_wait_elapsed <= 1'b0;
        end else begin
            r_scr         <= w_nxt_scr;
            r_start_state <= (w_nxt_scr == SCR_START);
            r_game_state  <= (w_nxt_scr == SCR_GAME);
            r_wait_state  <= (w_nxt_scr == SCR_WAIT);
            r_new_game    <= w_apply && (w_req_scr == SCR_GAME) && (w_req_kind == REQ_NEW);
            r_next_hand   <= w_apply && (w_req_scr == SCR_GAME) && (w_req_kind == REQ_NEXT);

            if (w_apply) begin
                r_pend_vld <= 1'b0;
            end else if (w_ev_vld) begin
                r_pend_vld  <= 1'b1;
                r_pend_scr  <= w_ev_scr;
                r_pend_kind <= w_ev_kind;
            end

            // game_over is captured with the accepted hand_done, not later.
            if (w_apply && (w_req_scr == SCR_START))
                r_over <= 1'b0;
            else if (w_ev_vld && (r_scr == SCR_GAME))
                r_over <= game_over;

            r_fcnt         <= w_fcnt_nxt;
            r_wait_elapsed <= (w_fcnt_nxt == WAIT_MAX) && (w_nxt_scr == SCR_WAIT);
        end
    end

    assign start_state  = r_start_state;
    assign game_state   = r_game_state;
    assign wait_state   = r_wait_state;
    assign new_game     = r_new_game;
    assign next_hand    = r_next_hand;
    assign wait_elapsed = r_wait_elapsed;

endmodule

// File: tb/tb_screen_mode_ctrl.sv
// Directed plus randomized bench for screen_mode_ctrl against a behavioural screen model.
module tb_screen_mode_ctrl;

`ifdef SCREEN_AUTO_ADVANCE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif
    localparam int W = 120;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame_start = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic       hand_done = 1'b0;
    logic       game_over = 1'b0;
    logic       start_state, game_state, wait_state, new_game, next_hand, wait_elapsed;

    int vec = 0, mis = 0;
    int ng_cnt = 0, nh_cnt = 0;

    // model: screens 0=start 1=game 2=wait
    int         m_scr = 0, m_ps = 0, m_cnt = 0;
    bit         m_pv = 0, m_pn = 0, m_over = 0, m_ng = 0, m_nh = 0;
    logic [7:0] m_prev = 8'h00;

    always #5 clk = ~clk;

    screen_mode_ctrl dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .keycode(keycode),
        .hand_done(hand_done), .game_over(game_over),
        .start_state(start_state), .game_state(game_state), .wait_state(wait_state),
        .new_game(new_game), .next_hand(next_hand), .wait_elapsed(wait_elapsed)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit es, ec, el, rv, rn, latch;
        int rs;
        if (!reset_n) begin
            m_scr = 0; m_pv = 0; m_over = 0; m_cnt = 0; m_prev = 8'h00; m_ng = 0; m_nh = 0;
        end else begin
            es = (keycode == 8'h28) && (m_prev != 8'h28);
            ec = (keycode == 8'h2C) && (m_prev != 8'h2C);
            el = (m_cnt == W) && (m_scr == 2);
            rv = m_pv; rs = m_ps; rn = m_pn; latch = 0;
            if (!m_pv) begin
                if (m_scr == 0 && es) begin rv = 1; rs = 1; rn = 1; end
                else if (m_scr == 1 && hand_done) begin rv = 1; rs = 2; latch = 1; end
                else if (m_scr == 2 && el && (ec || AUTO)) begin rv = 1; rs = m_over ? 0 : 1; rn = 0; end
            end
            if (latch) m_over = game_over;
            m_ng = 0; m_nh = 0;
            if (frame_start && rv) begin
                if (rs == 1) begin m_ng = rn; m_nh = !rn; end
                if (rs == 0) m_over = 0;
                if (rs == 2) m_cnt = 0;
                m_scr = rs; m_pv = 0;
            end else begin
                m_pv = rv; m_ps = rs; m_pn = rn;
                if (m_scr == 2 && frame_start && m_cnt < W) m_cnt++;
            end
            m_prev = keycode;
        end
    endtask

    // One clock: model advances with the pre-edge inputs, DUT checked 1ns later.
    task automatic cyc();
        logic [5:0] exp_v, act_v;
        @(posedge clk);
        model_step();
        #1;
        exp_v = {m_scr == 0, m_scr == 1, m_scr == 2, m_ng, m_nh, (m_scr == 2) && (m_cnt == W)};
        act_v = {start_state, game_state, wait_state, new_game, next_hand, wait_elapsed};
        chk("outputs", act_v, exp_v);
        chk("onehot", 32'(start_state) + 32'(game_state) + 32'(wait_state), 1);
        if (new_game)  ng_cnt++;
        if (next_hand) nh_cnt++;
    endtask

    task automatic frames(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            frame_start = 1'b1; cyc(); frame_start = 1'b0;
            repeat (gap - 1) cyc();
        end
    endtask

    task automatic press(input logic [7:0] k);
        keycode = k; cyc(); keycode = 8'h00; cyc();
    endtask

    initial begin
        int k;
        reset_n = 1'b0;
        cyc(); cyc();
        chk("reset_start", start_state, 1);
        chk("reset_game", game_state, 0);
        chk("reset_elapsed", wait_elapsed, 0);
        reset_n = 1'b1;

        // Enter held across three frames: one new_game only
        keycode = 8'h28;
        repeat (3) cyc();
        chk("start_hold_pre_frame", start_state, 1);
        frames(3, 8);
        keycode = 8'h00;
        chk("enter_game", game_state, 1);
        chk("enter_one_pulse", ng_cnt, 1);

        // hand_done, frame 5 cycles later
        game_over = 1'b0; hand_done = 1'b1; cyc(); hand_done = 1'b0;
        repeat (4) cyc();
        frame_start = 1'b1; cyc(); frame_start = 1'b0;
        chk("wait_entry", wait_state, 1);
        chk("wait_entry_elapsed", wait_elapsed, 0);
        press(8'h2C);
        frames(10, 4);
        chk("early_space_ignored", wait_state, 1);
        k = 10;
        while (k < 200) begin
            k++;
            frame_start = 1'b1; cyc(); frame_start = 1'b0;
            if (wait_elapsed) break;
            repeat (3) cyc();
        end
        chk("elapsed_frame", k, 120);
        press(8'h2C);
        frames(1, 4);
        chk("next_game", game_state, 1);
        chk("next_pulse", nh_cnt, 1);
        chk("no_extra_new", ng_cnt, 1);

        // hand_done coincident with frame_start, game over
        frame_start = 1'b1; hand_done = 1'b1; game_over = 1'b1; cyc();
        frame_start = 1'b0; hand_done = 1'b0; game_over = 1'b0;
        chk("coincident_wait", wait_state, 1);
        frames(120, 4);
        chk("over_elapsed", wait_elapsed, 1);
        press(8'h2C);
        frames(1, 4);
        chk("over_to_start", start_state, 1);
        press(8'h28);
        frames(1, 4);
        chk("restart_game", game_state, 1);
        chk("restart_new", ng_cnt, 2);

        // reset while a start->game request is pending
        reset_n = 1'b0; cyc(); reset_n = 1'b1;
        press(8'h28);
        reset_n = 1'b0; cyc(); reset_n = 1'b1;
        frames(2, 4);
        chk("reset_discard_start", start_state, 1);
        chk("reset_discard_pulse", ng_cnt, 2);

        // randomized traffic
        for (int i = 0; i < 8000; i++) begin
            int r;
            reset_n     = ($urandom_range(0, 499) != 0);
            frame_start = ($urandom_range(0, 4) == 0);
            hand_done   = ($urandom_range(0, 9) == 0);
            game_over   = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            if (r < 5)      keycode = 8'h00;
            else if (r < 7) keycode = 8'h28;
            else if (r < 9) keycode = 8'h2C;
            else            keycode = 8'($urandom);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end

endmodule

// File: doc/screen_mode_ctrl.md
Name: screen_mode_ctrl

Overview:
- Upstream sequencer for the top-level screen mux. Produces the one-hot start_state / game_state / wait_state selects consumed by top_screen.
- Reacts to keyboard keycodes and to hand/game completion from the poker game FSM.
- Screen changes occur only at frame boundaries, so no frame is drawn with mixed screens.
- Issues one-cycle new_game / next_hand pulses to the game FSM, aligned with the switch to the game screen.

Parameters:
- KEY_START, 8'h28, keycode that starts a game from the start screen (Enter).
- KEY_CONT, 8'h2C, keycode that leaves the wait screen (Space).
- WAIT_FRAMES, 120, minimum frames the wait screen is shown before wait_elapsed rises.
- FCNT_W, 8, width of the wait-frame counter; must hold WAIT_FRAMES.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, reset, synchronous and active-low.
- frame_start, in, 1, one-cycle pulse at the start of vertical blanking.
- keycode, in, 8, current keyboard keycode; 0 means no key.
- hand_done, in, 1, one-cycle pulse from the game FSM when a hand is resolved.
- game_over, in, 1, level from the game FSM; a player's stack is 0.
- start_state, out, 1, start screen selected.
- game_state, out, 1, game screen selected.
- wait_state, out, 1, wait screen selected.
- new_game, out, 1, one-cycle pulse: reset stacks and deal.
- next_hand, out, 1, one-cycle pulse: deal the next hand.
- wait_elapsed, out, 1, WAIT_FRAMES reached in the current wait screen.

Behaviour:
- Reset (reset_n low at a clk edge):
  - start_state=1; game_state=0; wait_state=0.
  - new_game=0; next_hand=0; wait_elapsed=0.
  - pending cleared, over flag cleared, frame counter=0, previous-key register=0.
- Outputs are registered. Exactly one select is high on every cycle.
- Key event: keycode==K this cycle and the previous-cycle keycode!=K (rising edge only). A held key produces one event.
- Displayed states and event handling:
  - START: a KEY_START event requests GAME with kind NEW.
  - GAME: keys are ignored. hand_done requests WAIT and latches over flag = game_over, sampled in the same cycle.
  - WAIT: a KEY_CONT event is accepted only when wait_elapsed=1.
    - over flag=1: request START.
    - over flag=0: request GAME with kind NEXT.
- pending holds one requested target.
  - While pending is valid, further events are ignored.
  - hand_done outside GAME is ignored.
  - Keys in GAME are ignored.
- Apply rule: at a clk edge where frame_start=1, if pending is valid (or an event occurs that same cycle), the selects switch at that edge and pending clears.
  - Otherwise the request waits for the next frame_start.
  - Worst-case latency is one frame plus one cycle. Best case is the same cycle.
- new_game / next_hand rise on the same edge that game_state rises, for one cycle only, according to the request kind.
- Entering START clears the over flag.
- Wait counter:
  - Cleared on entry to WAIT.
  - Increments on each frame_start while in WAIT, excluding the entry edge.
  - Saturates at WAIT_FRAMES. wait_elapsed = (count==WAIT_FRAMES) && wait_state.
- Simultaneous hand_done and frame_start in GAME: WAIT is applied on that edge.
- Reset mid-request: the pending request is discarded and no pulse is emitted.

Optional Feature:
- Macro: SCREEN_AUTO_ADVANCE_EN.
- Defined: when in WAIT with wait_elapsed=1 and pending empty, the block self-generates the KEY_CONT request.
  - The WAIT to GAME/START transition occurs at the frame_start after the counter saturates (WAIT_FRAMES+1 frames total).
  - Keys still work.
- Undefined: leaving WAIT requires a KEY_CONT event.

Decomposition:
- poker_types.svh gets:
  - screen_t enum: SCR_START, SCR_GAME, SCR_WAIT.
  - req_kind_t enum: REQ_NEW, REQ_NEXT.
  - Keycode constants used for the KEY_START / KEY_CONT defaults.
- One sub-module, key_edge_detect:
  - Parameter KEY.
  - Ports: clk, reset_n, keycode in; one-cycle event out.
  - Instanced twice.

Test Plan:
- Reset, then KEY_START (8'h28) held 3 frames: start_state stays 1 until the next frame_start edge, then game_state=1 with one new_game pulse. Holding the key produces no second pulse.
- In GAME, hand_done with game_over=0, then frame_start 5 cycles later: wait_state=1 at that edge, counter=0. Space pressed before 120 frames: ignored.
- After 120 frames in WAIT (wait_elapsed=1), Space: game_state=1 at the next frame_start with a single next_hand pulse. new_game stays 0.
- hand_done with game_over=1, wait 120 frames, Space: start_state=1 and the over flag is cleared. The next Enter yields new_game.
- hand_done coincident with frame_start: wait_state=1 on that same edge. reset_n=0 while a START→GAME request is pending: start_state=1 and no pulse ever.
- SCREEN_AUTO_ADVANCE_EN defined, no keys: WAIT→GAME exactly 121 frame_start pulses after entry, with one next_hand pulse.
